// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions for the interrupt controller: CALL opcode,
// controller FSM states, vector address width and instruction-building helpers.
package cpu_pkg;

    localparam logic [4:0] OP_CALL    = 5'b11001;
    localparam int         VEC_ADDR_W = 16;
    localparam int         CALL_W     = 29;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } irq_state_e;

    // Index width that stays legal for a single-channel build
    function automatic int id_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    // Handler address with natural 16-bit wrap
    function automatic logic [VEC_ADDR_W-1:0] vec_addr(
        input logic [VEC_ADDR_W-1:0] base,
        input logic [VEC_ADDR_W-1:0] stride,
        input logic [VEC_ADDR_W-1:0] idx
    );
        return base + idx * stride;
    endfunction

    function automatic logic [CALL_W-1:0] call_word(input logic [VEC_ADDR_W-1:0] addr);
        return {OP_CALL, 8'h00, addr};
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// CPU-facing injection handshake of the interrupt controller.
interface irq_ctrl_if
    import cpu_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int INST_W  = 29
) ();
    localparam int ID_W = id_width(NUM_IRQ);

    logic              irq_req;
    logic [INST_W-1:0] irq_inst;
    logic [ID_W-1:0]   irq_id;
    logic              irq_ack;
    logic              irq_done;

    // CPU side
    modport master (
        input  irq_req,
        input  irq_inst,
        input  irq_id,
        output irq_ack,
        output irq_done
    );

    // Controller side
    modport slave (
        output irq_req,
        output irq_inst,
        output irq_id,
        input  irq_ack,
        input  irq_done
    );
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag.
module irq_prio_enc #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan high to low so the lowest set bit is the last one written
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx_o = req_i[i] ? IDX_W'(i) : idx_o;
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Vectored interrupt controller that injects a CALL into the CPU fetch path.
// Define IRQ_NEST_EN to let a higher-priority channel preempt a running handler.
module irq_ctrl
    import cpu_pkg::*;
#(
    parameter int              NUM_IRQ    = 8,
    parameter int              INST_W     = 29,
    parameter logic [15:0]     VEC_BASE   = 16'hFF00,
    parameter logic [15:0]     VEC_STRIDE = 16'h0004
) (
    input  logic               clk_bus,
    input  logic               rst_bus,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic [NUM_IRQ-1:0] irq_edge,
    input  logic               gie,
    irq_ctrl_if.slave          cpu,
    output logic [NUM_IRQ-1:0] pend_out,
    output logic [NUM_IRQ-1:0] isr_out
);

    localparam int ID_W = id_width(NUM_IRQ);

    irq_state_e        state_q, state_d;
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] isr_q, isr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [INST_W-1:0]  inst_q, inst_d;

    logic [NUM_IRQ-1:0] rise_s;
    logic [NUM_IRQ-1:0] ack_oh_s;
    logic [NUM_IRQ-1:0] isr_done_s;
    logic [NUM_IRQ-1:0] prio_mask_s;
    logic [NUM_IRQ-1:0] cand_s;
    logic               ack_s;
    logic               enc_valid_s;
    logic [ID_W-1:0]    enc_idx_s;

    // Pending / in-service next state; done-clear is applied before ack-set
    always_comb begin
        rise_s     = irq_in & ~prev_q;
        ack_s      = (state_q == ST_REQ) && cpu.irq_ack;
        ack_oh_s   = ack_s ? (NUM_IRQ'(1) << id_q) : '0;
        isr_done_s = cpu.irq_done ? (isr_q & (isr_q - NUM_IRQ'(1))) : isr_q;
        isr_d      = isr_done_s | ack_oh_s;
        pend_d     = (irq_edge & ((pend_q & ~ack_oh_s) | rise_s)) | (~irq_edge & irq_in);
    end

    // Candidates limited by the handler currently in service
    always_comb begin
`ifdef IRQ_NEST_EN
        prio_mask_s = (isr_q & (~isr_q + NUM_IRQ'(1))) - NUM_IRQ'(1);
`else
        prio_mask_s = (isr_q == '0) ? '1 : '0;
`endif
        cand_s = pend_q & irq_en & ~isr_q & prio_mask_s & {NUM_IRQ{gie}};
    end

    irq_prio_enc #(
        .N     (NUM_IRQ),
        .IDX_W (ID_W)
    ) u_prio (
        .req_i   (cand_s),
        .valid_o (enc_valid_s),
        .idx_o   (enc_idx_s)
    );

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enc_valid_s) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (cpu.irq_ack || !gie) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: id and instruction latched only on IDLE->REQ
    always_comb begin
        id_d   = id_q;
        inst_d = inst_q;
        if ((state_q == ST_IDLE) && enc_valid_s) begin
            id_d   = enc_idx_s;
            inst_d = INST_W'(call_word(vec_addr(VEC_BASE, VEC_STRIDE, VEC_ADDR_W'(enc_idx_s))));
        end else begin
            id_d   = id_q;
            inst_d = inst_q;
        end
    end

    // State register
    always_ff @(posedge clk_bus) begin
        if (!rst_bus) begin
            state_q <= ST_IDLE;
            prev_q  <= '0;
            pend_q  <= '0;
            isr_q   <= '0;
            id_q    <= '0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= irq_in;
            pend_q  <= pend_d;
            isr_q   <= isr_d;
            id_q    <= id_d;
            inst_q  <= inst_d;
        end
    end

    assign cpu.irq_req  = (state_q == ST_REQ);
    assign cpu.irq_id   = id_q;
    assign cpu.irq_inst = inst_q;
    assign pend_out     = pend_q;
    assign isr_out      = isr_q;

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 8, SHALL set the number of interrupt channels, legal range 1..16.
REQ-002 Parameter INST_W, default 29, SHALL set the width of the injected instruction word.
REQ-003 Parameter VEC_BASE, default 16'hFF00, SHALL set the handler address of channel 0.
REQ-004 Parameter VEC_STRIDE, default 16'h0004, SHALL set the handler address spacing between channels.
REQ-005 clk_bus  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst_bus  input  1  SHALL be the reset: synchronous, active-low.
REQ-007 irq_in  input  NUM_IRQ  SHALL carry the raw interrupt sources.
REQ-008 irq_en  input  NUM_IRQ  SHALL be the per-channel enable mask.
REQ-009 irq_edge  input  NUM_IRQ  SHALL select the trigger mode per channel: 1 = rising edge, 0 = level-high.
REQ-010 gie  input  1  SHALL be the global interrupt enable.
REQ-011 irq_ack  input  1  SHALL be the CPU's one-cycle acceptance of the injected instruction.
REQ-012 irq_done  input  1  SHALL be the CPU's one-cycle return-from-interrupt strobe.
REQ-013 irq_req  output  1  SHALL indicate that irq_inst is valid; the CPU then substitutes it for the ROM word.
REQ-014 irq_inst  output  INST_W  SHALL be the injected CALL instruction.
REQ-015 irq_id  output  clog2(NUM_IRQ)  SHALL be the index of the channel being requested.
REQ-016 pend_out  output  NUM_IRQ  SHALL expose the pending register.
REQ-017 isr_out  output  NUM_IRQ  SHALL expose the in-service register.

Function
REQ-018 Edge channel: the pending bit SHALL set on the clock where irq_in=1 and its registered previous sample=0.
REQ-019 Level channel: the pending bit SHALL equal the registered irq_in.
REQ-020 Candidate set SHALL be pend & irq_en & ~isr, gated by gie; the lowest index wins.
REQ-021 Preemption limit: a candidate SHALL also have an index below the lowest set isr bit (nesting per REQ-035).
REQ-022 FSM SHALL have two states, IDLE and REQ.
  - IDLE->REQ on the clock after a candidate exists; irq_id is latched on that transition.
  - REQ->IDLE on irq_ack, or when gie=0.
REQ-023 While in REQ, irq_req SHALL be 1 and irq_id/irq_inst SHALL hold stable; there is no re-arbitration.
REQ-024 irq_inst SHALL be {OP_CALL, 8'h00, VEC_BASE + irq_id*VEC_STRIDE}, truncated to 16 bits with modulo wrap.
REQ-025 On irq_ack in REQ, isr[irq_id] SHALL set; for edge channels pend[irq_id] SHALL clear.
REQ-026 A new edge on the channel being acknowledged, in the same cycle as irq_ack, SHALL leave pend=1 (set wins).
REQ-027 On irq_done, the lowest-index set isr bit SHALL clear.
  - irq_done with isr=0 is ignored.
  - irq_ack while in IDLE is ignored.
REQ-028 irq_ack and irq_done in the same cycle: the done-clear SHALL apply first, then the ack-set.
REQ-029 Minimum latency from an irq_in edge to irq_req=1 SHALL be 2 clocks.
REQ-030 Clearing irq_en for a channel SHALL NOT clear its pending bit; the bit is only masked.

Reset
REQ-031 With rst_bus=0 at a clock edge, pend, isr and the edge-history registers SHALL reset to 0 and the FSM to IDLE.
REQ-032 During and after reset, irq_req=0, irq_id=0 and irq_inst=0 SHALL hold until a new request is formed.
REQ-033 Reset mid-REQ SHALL abort the request; no isr bit is set.
REQ-034 Edges present during reset SHALL be lost; level sources re-pend after reset.

Configuration
REQ-035 Macro IRQ_NEST_EN defined: preemption SHALL follow REQ-021.
  - Macro undefined: no candidate is formed while isr != 0, and REQ-027 clears the single set bit.

Structure
REQ-036 Package cpu_pkg SHALL hold OP_CALL (5-bit opcode), the FSM state typedef, and the vector-address width constant.
REQ-037 One sub-module, irq_prio_enc (parametrised lowest-index priority encoder with valid output), SHALL provide arbitration.

Verification
REQ-038 Reset: rst_bus=0 for 2 clocks with irq_in=8'hFF -> irq_req=0, pend_out=0, isr_out=0.
REQ-039 Single edge: ch3 edge, gie=1, en=8'hFF -> irq_req=1 two clocks later, irq_id=3, irq_inst={OP_CALL,8'h00,16'hFF0C}; irq_ack -> isr_out=8'h08, pend_out=8'h00.
REQ-040 Priority: ch5 and ch2 edges in the same cycle -> irq_id=2 first; ack + done -> irq_id=5 next.
REQ-041 Nesting (IRQ_NEST_EN): isr=8'h10, ch1 edge -> irq_req with id 1, isr=8'h12 after ack.
  - Without the macro: no irq_req until irq_done.
REQ-042 Simultaneous: irq_ack (id 1) with irq_done while isr=8'h10 -> isr=8'h02.
  - ch1 edge coincident with its ack -> pend_out[1]=1.
REQ-043 Abort: gie dropped to 0 during REQ -> irq_req=0 next clock, isr unchanged, pending retained.
